// File: rtl/aes_pkg.sv
// Constants, FSM encodings and GF(2^8) helpers shared by the AES key schedule.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'h0;
    localparam logic       AES_256_BIT_KEY = 1'h1;

    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    localparam int         NUM_KEYS        = 15;
    localparam logic [7:0] RCON_SEED       = 8'h8d;

    localparam logic [1:0] CTRL_IDLE       = 2'h0;
    localparam logic [1:0] CTRL_INIT       = 2'h1;
    localparam logic [1:0] CTRL_GENERATE   = 2'h2;
    localparam logic [1:0] CTRL_DONE       = 2'h3;

    typedef logic [127:0] round_key_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational SubWord: four byte S-boxes (GF(2^8) inverse then affine map).
// Zero latency, no flow control.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        new_sboxw = '0;
        for (int b = 0; b < 4; b++) begin
            new_sboxw[b*8 +: 8] = sbox_byte(sboxw[b*8 +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_mem.sv
// AES-128/256 key expansion into a 15-entry round-key store, one key per cycle.
// Ready 13 (AES-128) / 17 (AES-256) cycles after init; init ignored while busy; reads are zero-latency.
module aes_key_mem
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           init,
    input  logic [255:0]   key,
    input  logic           keylen,
    input  logic [3:0]     round,
    output logic [127:0]   round_key,
    output logic           ready
);

    round_key_t  key_mem [0:NUM_KEYS-1];
    round_key_t  prev0;
    round_key_t  prev1;
    round_key_t  base;
    round_key_t  next_key;
    logic [7:0]  rcon_reg;
    logic [7:0]  rcon_next;
    logic [3:0]  round_ctr;
    logic [3:0]  num_rounds;
    logic [1:0]  state;
    logic        keylen_reg;
    logic        ready_reg;
    logic        rotate;
    logic        gen_word;
    logic        rcon_step;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;
    logic [31:0] t;
    logic [31:0] k0, k1, k2, k3;

    aes_sbox u_sbox (
        .sboxw     (sbox_in),
        .new_sboxw (sbox_out)
    );

    assign num_rounds = (keylen_reg == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    // AES-256 odd addresses use plain SubWord without rcon; everything else rotates and mixes rcon.
    always_comb begin
        rcon_next = xtime(rcon_reg);
        rotate    = (keylen_reg == AES_128_BIT_KEY) || !round_ctr[0];
        gen_word  = (round_ctr != 4'd0) &&
                    !((keylen_reg == AES_256_BIT_KEY) && (round_ctr == 4'd1));
        rcon_step = gen_word && rotate;
        sbox_in   = rotate ? {prev0[23:0], prev0[31:24]} : prev0[31:0];
        t         = sbox_out ^ (rotate ? {rcon_next, 24'h0} : 32'h0);
        base      = (keylen_reg == AES_256_BIT_KEY) ? prev1 : prev0;
        k0        = base[127:96] ^ t;
        k1        = base[95:64]  ^ k0;
        k2        = base[63:32]  ^ k1;
        k3        = base[31:0]   ^ k2;
        if (round_ctr == 4'd0) begin
            next_key = key[255:128];
        end else if (!gen_word) begin
            next_key = key[127:0];
        end else begin
            next_key = {k0, k1, k2, k3};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            prev0      <= '0;
            prev1      <= '0;
            rcon_reg   <= RCON_SEED;
            round_ctr  <= 4'd0;
            state      <= CTRL_IDLE;
            keylen_reg <= AES_128_BIT_KEY;
            ready_reg  <= 1'b0;
        end else begin
            case (state)
                CTRL_IDLE: begin
                    if (init) begin
                        keylen_reg <= keylen;
                        ready_reg  <= 1'b0;
                        state      <= CTRL_INIT;
                    end
                end
                CTRL_INIT: begin
                    round_ctr <= 4'd0;
                    rcon_reg  <= RCON_SEED;
                    state     <= CTRL_GENERATE;
                end
                CTRL_GENERATE: begin
                    key_mem[round_ctr] <= next_key;
                    prev1              <= prev0;
                    prev0              <= next_key;
                    if (rcon_step) begin
                        rcon_reg <= rcon_next;
                    end
                    round_ctr <= round_ctr + 4'd1;
                    if (round_ctr == num_rounds) begin
                        state <= CTRL_DONE;
                    end
                end
                CTRL_DONE: begin
                    ready_reg <= 1'b1;
                    state     <= CTRL_IDLE;
                end
                default: state <= CTRL_IDLE;
            endcase
        end
    end

    assign round_key = (round == 4'hf) ? '0 : key_mem[round];
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_key_mem.sv
// Bench for aes_key_mem: FIPS-197 vectors, corner sequences and random keys against a word-level model.
module tb_aes_key_mem;

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_rk [15];

    typedef struct packed {
        logic [255:0] key;
        logic         kl;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [9];

    aes_key_mem dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .key       (key),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // S-box table from the generator/log walk, independent of any inverse computation.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // FIPS-197 word-oriented expansion.
    task automatic model_expand(input logic [255:0] k, input logic kl);
        logic [31:0] w [60];
        logic [31:0] temp;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0)
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
            else if (nk == 8 && i % 8 == 4)
                temp = sub_word(temp);
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Called at the negedge following edge 'start'; looks for the first edge after which ready is high.
    task automatic wait_ready(input int start, input int exp_lat, input string name);
        int lat;
        lat = -1;
        for (int c = start + 1; c <= start + 40; c++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        check(name, lat, exp_lat);
    endtask

    // Must be entered at a negedge; init is sampled by the next posedge (E0).
    task automatic run_expand(input logic [255:0] k, input logic kl, input string name);
        key    = k;
        keylen = kl;
        init   = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check({name, "_ready_low"}, ready, 1'b0);
        wait_ready(0, kl ? 17 : 13, {name, "_ready_lat"});
    endtask

    task automatic check_store(input logic kl, input string tag);
        int nr;
        nr = kl ? 14 : 10;
        for (int r = 0; r <= nr; r++) begin
            round = r[3:0];
            #1;
            check($sformatf("%s_r%0d", tag, r), round_key, exp_rk[r]);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] ka, kr;
        logic         kl;

        vt[0] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 4'd0,
                  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vt[1] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 4'd1,
                  128'ha0fafe1788542cb123a339392a6c7605};
        vt[2] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 4'd2,
                  128'hf2c295f27a96b9435935807a7359f67f};
        vt[3] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 4'd10,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[4] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1, 4'd0,
                  128'h603deb1015ca71be2b73aef0857d7781};
        vt[5] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1, 4'd1,
                  128'h1f352c073b6108d72d9810a30914dff4};
        vt[6] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1, 4'd2,
                  128'h9ba354118e6925afa51a8b5f2067fcde};
        vt[7] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1, 4'd14,
                  128'hfe4890d1e6188d0b046df344706c631e};
        vt[8] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1, 4'd15,
                  128'h0};

        reset  = 1'b1;
        init   = 1'b0;
        key    = '0;
        keylen = 1'b0;
        round  = 4'd0;
        build_sbox();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_ready", ready, 1'b0);
        check("reset_r0", round_key, 128'h0);
        round = 4'd14;
        #1;
        check("reset_r14", round_key, 128'h0);

        // Known-answer vectors; re-expand whenever the key or length changes.
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || vt[i].key != vt[i-1].key || vt[i].kl != vt[i-1].kl) begin
                @(negedge clk);
                run_expand(vt[i].key, vt[i].kl, $sformatf("kat%0d", i));
            end
            round = vt[i].rnd;
            #1;
            check($sformatf("kat%0d_round%0d", i, vt[i].rnd), round_key, vt[i].exp);
        end

        // Second init at E5 while generating must be ignored; addresses past 1 never read the key input.
        ka = vt[0].key;
        @(negedge clk);
        key = ka; keylen = 1'b0; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (4) @(negedge clk);
        key = rand256(); keylen = 1'b1; init = 1'b1;
        @(negedge clk);
        init = 1'b0; key = ka; keylen = 1'b0;
        wait_ready(5, 13, "busy_ready_lat");
        model_expand(ka, 1'b0);
        check_store(1'b0, "busy");

        // Reset asserted over E6 aborts the expansion and clears the store.
        kr = rand256();
        key = kr; keylen = 1'b1; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", ready, 1'b0);
        for (int r = 0; r < 16; r++) begin
            round = r[3:0];
            #1;
            check($sformatf("abort_r%0d", r), round_key, 128'h0);
        end
        @(negedge clk);
        kr = rand256();
        run_expand(kr, 1'b0, "post_abort");
        model_expand(kr, 1'b0);
        check_store(1'b0, "post_abort");

        // Back-to-back: the AES-128 init lands on the edge right after ready rises.
        kr = rand256();
        run_expand(kr, 1'b1, "b2b256");
        kr = rand256();
        run_expand(kr, 1'b0, "b2b128");
        model_expand(kr, 1'b0);
        check_store(1'b0, "b2b128");

        for (int it = 0; it < 6; it++) begin
            kr = rand256();
            kl = 1'($urandom_range(0, 1));
            run_expand(kr, kl, $sformatf("rnd%0d", it));
            model_expand(kr, kl);
            check_store(kl, $sformatf("rnd%0d", it));
            round = 4'hf;
            #1;
            check($sformatf("rnd%0d_r15", it), round_key, 128'h0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
